// File: rtl/lvds_lcd_mapper.sv
// Maps 24-bit clocked-video pixels onto four 7-bit LVDS lanes (VESA or JEIDA) with frame-lock gating.
// Latency: 2 cycles input-to-lvds_tx_data. No backpressure: the video stream is consumed every cycle.
module lvds_lcd_mapper #(
   parameter int H_ACTIVE    = 800,
   parameter int V_ACTIVE    = 480,
   parameter int LOCK_FRAMES = 2,
   parameter int JEIDA       = 0
) (
   input  logic        clk_clk,
   input  logic        reset_reset_n,
   input  logic [23:0] vid_data,
   input  logic        vid_datavalid,
   input  logic        vid_h_sync,
   input  logic        vid_v_sync,
   input  logic        vid_underflow,
   input  logic        clear_err,
   output logic [27:0] lvds_tx_data,
   output logic        frame_locked,
   output logic        underflow_sticky,
   output logic [11:0] meas_h,
   output logic [11:0] meas_v
);

   typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

   localparam logic [11:0] LP_H    = 12'(H_ACTIVE);
   localparam logic [11:0] LP_V    = 12'(V_ACTIVE);
   localparam logic [4:0]  LP_LOCK = 5'(LOCK_FRAMES);
   localparam logic [11:0] LP_SAT  = 12'hFFF;

   // stage 1
   logic [23:0] r_data;
   logic        r_de;
   logic        r_hs;
   logic        r_vs;
   logic        r_uf;
   logic        r_clr;
   logic        r_de_d;
   logic        r_vs_d;

   logic [11:0] r_hcnt;
   logic [11:0] r_vcnt;
   logic        r_line_bad;
   logic [3:0]  r_match_cnt;
   state_t      r_state;

   logic [27:0] r_tx;
   logic        r_locked;
   logic        r_sticky;
   logic [11:0] r_meas_h;
   logic [11:0] r_meas_v;

   logic        w_de_rise;
   logic        w_de_fall;
   logic        w_vs_rise;
   logic        w_bad_now;
   logic        w_match;
   logic [4:0]  w_cnt_inc;
   logic        w_lock_nxt;
   logic [23:0] w_px;
   logic [7:0]  w_r;
   logic [7:0]  w_g;
   logic [7:0]  w_b;
   logic        w_de_o;
   logic [6:0]  w_lane0;
   logic [6:0]  w_lane1;
   logic [6:0]  w_lane2;
   logic [6:0]  w_lane3;

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         r_data <= '0;
         r_de   <= 1'b0;
         r_hs   <= 1'b0;
         r_vs   <= 1'b0;
         r_uf   <= 1'b0;
         r_clr  <= 1'b0;
         r_de_d <= 1'b0;
         r_vs_d <= 1'b0;
      end else begin
         r_data <= vid_data;
         r_de   <= vid_datavalid;
         r_hs   <= vid_h_sync;
         r_vs   <= vid_v_sync;
         r_uf   <= vid_underflow;
         r_clr  <= clear_err;
         r_de_d <= r_de;
         r_vs_d <= r_vs;
      end
   end

   assign w_de_rise = r_de & ~r_de_d;
   assign w_de_fall = ~r_de & r_de_d;
   assign w_vs_rise = r_vs & ~r_vs_d;

   // A line ending on the same cycle as v_sync still belongs to the frame being closed.
   assign w_bad_now  = r_line_bad | (w_de_fall && (r_hcnt != LP_H));
   assign w_match    = ~w_bad_now && (r_vcnt == LP_V);
   assign w_cnt_inc  = {1'b0, r_match_cnt} + 5'd1;

   assign w_lock_nxt = ~r_uf &&
                       (((r_state == LOCKED) && !(w_vs_rise && !w_match)) ||
                        ((r_state == MEASURE) && w_vs_rise && w_match && (w_cnt_inc >= LP_LOCK)));

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         r_hcnt     <= '0;
         r_vcnt     <= '0;
         r_line_bad <= 1'b0;
         r_meas_h   <= '0;
         r_meas_v   <= '0;
      end else begin
         if (w_de_fall) begin
            r_meas_h <= r_hcnt;
            r_hcnt   <= '0;
         end else if (r_de && (r_hcnt != LP_SAT)) begin
            r_hcnt <= r_hcnt + 12'd1;
         end

         if (w_vs_rise) begin
            r_meas_v   <= r_vcnt;
            r_vcnt     <= w_de_rise ? 12'd1 : 12'd0;
            r_line_bad <= 1'b0;
         end else begin
            if (w_de_rise && (r_vcnt != LP_SAT)) begin
               r_vcnt <= r_vcnt + 12'd1;
            end
            if (w_de_fall && (r_hcnt != LP_H)) begin
               r_line_bad <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         r_state     <= SEARCH;
         r_match_cnt <= '0;
         r_locked    <= 1'b0;
      end else begin
         r_locked <= w_lock_nxt;
         if (r_uf) begin
            r_state     <= SEARCH;
            r_match_cnt <= '0;
         end else if (w_vs_rise) begin
            case (r_state)
               SEARCH: begin
                  r_state     <= MEASURE;
                  r_match_cnt <= '0;
               end
               MEASURE: begin
                  if (w_match) begin
                     r_match_cnt <= w_cnt_inc[3:0];
                     if (w_cnt_inc >= LP_LOCK) begin
                        r_state <= LOCKED;
                     end
                  end else begin
                     r_match_cnt <= '0;
                  end
               end
               LOCKED: begin
                  if (!w_match) begin
                     r_state     <= SEARCH;
                     r_match_cnt <= '0;
                  end
               end
               default: begin
                  r_state     <= SEARCH;
                  r_match_cnt <= '0;
               end
            endcase
         end
      end
   end

   // Set has priority over clear so a coincident underflow is never lost.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         r_sticky <= 1'b0;
      end else if (r_uf) begin
         r_sticky <= 1'b1;
      end else if (r_clr) begin
         r_sticky <= 1'b0;
      end
   end

   // Gate with the lock state this pixel produces, so blanking lands on the causing pixel.
   assign w_px   = w_lock_nxt ? r_data : 24'd0;
   assign w_de_o = w_lock_nxt & r_de;
   assign w_r    = w_px[23:16];
   assign w_g    = w_px[15:8];
   assign w_b    = w_px[7:0];

   generate
      if (JEIDA != 0) begin : g_jeida
         assign w_lane0 = {w_g[2], w_r[7:2]};
         assign w_lane1 = {w_b[3:2], w_g[7:3]};
         assign w_lane2 = {w_de_o, r_vs, r_hs, w_b[7:4]};
         assign w_lane3 = {1'b0, w_b[1:0], w_g[1:0], w_r[1:0]};
      end else begin : g_vesa
         assign w_lane0 = {w_g[0], w_r[5:0]};
         assign w_lane1 = {w_b[1:0], w_g[5:1]};
         assign w_lane2 = {w_de_o, r_vs, r_hs, w_b[5:2]};
         assign w_lane3 = {1'b0, w_b[7:6], w_g[7:6], w_r[7:6]};
      end
   endgenerate

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         r_tx <= '0;
      end else begin
         r_tx <= {w_lane3, w_lane2, w_lane1, w_lane0};
      end
   end

   assign lvds_tx_data     = r_tx;
   assign frame_locked     = r_locked;
   assign underflow_sticky = r_sticky;
   assign meas_h           = r_meas_h;
   assign meas_v           = r_meas_v;

endmodule

// File: tb/tb_lvds_lcd_mapper.sv
// Directed bench for lvds_lcd_mapper: small 8x4 frames, VESA and JEIDA instances driven in parallel.
module tb_lvds_lcd_mapper;

   localparam int H = 8;
   localparam int V = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [23:0] vid_data;
   logic        de, hs, vs, uf, clr;

   logic [27:0] tx_v, tx_j;
   logic        locked_v, locked_j, sticky_v, sticky_j;
   logic [11:0] mh_v, mv_v, mh_j, mv_j;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   lvds_lcd_mapper #(.H_ACTIVE(H), .V_ACTIVE(V), .LOCK_FRAMES(2), .JEIDA(0)) u_vesa (
      .clk_clk(clk), .reset_reset_n(rst_n), .vid_data(vid_data), .vid_datavalid(de),
      .vid_h_sync(hs), .vid_v_sync(vs), .vid_underflow(uf), .clear_err(clr),
      .lvds_tx_data(tx_v), .frame_locked(locked_v), .underflow_sticky(sticky_v),
      .meas_h(mh_v), .meas_v(mv_v));

   lvds_lcd_mapper #(.H_ACTIVE(H), .V_ACTIVE(V), .LOCK_FRAMES(2), .JEIDA(1)) u_jeida (
      .clk_clk(clk), .reset_reset_n(rst_n), .vid_data(vid_data), .vid_datavalid(de),
      .vid_h_sync(hs), .vid_v_sync(vs), .vid_underflow(uf), .clear_err(clr),
      .lvds_tx_data(tx_j), .frame_locked(locked_j), .underflow_sticky(sticky_j),
      .meas_h(mh_j), .meas_v(mv_j));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic line(input int len);
      hs = 1'b1; tick();
      hs = 1'b0; tick();
      for (int i = 0; i < len; i++) begin
         de = 1'b1; vid_data = 24'h123456; tick();
      end
      de = 1'b0; vid_data = 24'h0;
      tick(); tick();
   endtask

   task automatic body(input int n, input int short_idx);
      for (int i = 0; i < n; i++) line((i == short_idx) ? H - 1 : H);
   endtask

   task automatic vsync_pulse();
      vs = 1'b1; tick(); tick();
      vs = 1'b0; tick(); tick();
   endtask

   // Lock is sampled after the first and second cycle of the v_sync pulse.
   task automatic vsync_check(input string tag, input logic exp1, input logic exp2);
      vs = 1'b1; tick();
      check({tag, "_vs1"}, {31'd0, locked_v}, {31'd0, exp1});
      tick();
      check({tag, "_vs2"}, {31'd0, locked_v}, {31'd0, exp2});
      vs = 1'b0; tick(); tick();
   endtask

   logic [23:0] px [8];
   logic [27:0] ev [8];
   logic [27:0] ej [8];

   initial begin
      px = '{24'hFF0000, 24'h0F0000, 24'h000500, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
      ev = '{28'h070003F, 28'h010000F, 28'h0100140, 28'h0100000, 28'h0100000,
             28'h0100000, 28'h0100000, 28'h0100000};
      ej = '{28'h070003F, 28'h0700003, 28'h0900040, 28'h0100000, 28'h0100000,
             28'h0100000, 28'h0100000, 28'h0100000};

      rst_n = 1'b0; vid_data = 24'hFFFFFF; de = 1'b1; hs = 1'b1; vs = 1'b1; uf = 1'b0; clr = 1'b0;
      tick(); tick(); tick();
      check("rst_tx_v", {4'd0, tx_v}, 32'd0);
      check("rst_tx_j", {4'd0, tx_j}, 32'd0);
      check("rst_locked", {30'd0, locked_v, locked_j}, 32'd0);
      check("rst_sticky", {30'd0, sticky_v, sticky_j}, 32'd0);
      check("rst_meas_h", {8'd0, mh_v, mh_j}, 32'd0);
      check("rst_meas_v", {8'd0, mv_v, mv_j}, 32'd0);

      de = 1'b0; hs = 1'b0; vs = 1'b0; vid_data = 24'h0;
      rst_n = 1'b1; tick(); tick();

      // Unlocked: HS passes, DE and RGB blanked.
      hs = 1'b1; de = 1'b1; vid_data = 24'hFFFFFF; tick();
      hs = 1'b0; de = 1'b0; vid_data = 24'h0; tick();
      check("unlocked_hs_only", {4'd0, tx_v}, 32'h0040000);
      tick(); tick();

      vsync_pulse();
      body(V, -1);
      vsync_pulse();
      check("meas_h_800", {20'd0, mh_v}, H);
      check("meas_v_480", {20'd0, mv_v}, V);
      check("not_locked_yet", {31'd0, locked_v}, 32'd0);
      body(V, -1);
      vsync_check("lock3", 1'b0, 1'b1);

      // Locked line with directed pixels, outputs lag by one call.
      hs = 1'b1; tick();
      hs = 1'b0; tick();
      for (int i = 0; i < H; i++) begin
         de = 1'b1; vid_data = px[i]; tick();
         if (i > 0) begin
            check($sformatf("vesa_px%0d", i - 1), {4'd0, tx_v}, {4'd0, ev[i - 1]});
            check($sformatf("jeida_px%0d", i - 1), {4'd0, tx_j}, {4'd0, ej[i - 1]});
         end
      end
      de = 1'b0; vid_data = 24'h0; tick();
      check("vesa_px7", {4'd0, tx_v}, {4'd0, ev[7]});
      check("jeida_px7", {4'd0, tx_j}, {4'd0, ej[7]});
      tick();
      body(V - 1, -1);
      vsync_check("stay_locked", 1'b1, 1'b1);

      // Underflow while locked.
      hs = 1'b1; tick();
      hs = 1'b0; tick();
      de = 1'b1; vid_data = 24'hFFFFFF; uf = 1'b1; tick();
      de = 1'b0; vid_data = 24'h0; uf = 1'b0; tick();
      check("uf_unlock", {31'd0, locked_v}, 32'd0);
      check("uf_blank", {4'd0, tx_v}, 32'd0);
      check("uf_sticky", {31'd0, sticky_v}, 32'd1);
      clr = 1'b1; tick();
      clr = 1'b0; tick();
      check("clr_sticky", {31'd0, sticky_v}, 32'd0);
      clr = 1'b1; uf = 1'b1; tick();
      clr = 1'b0; uf = 1'b0; tick();
      check("set_wins", {31'd0, sticky_v}, 32'd1);
      clr = 1'b1; tick();
      clr = 1'b0; tick();
      check("clr_sticky2", {31'd0, sticky_v}, 32'd0);
      body(V - 1, -1);
      vsync_check("uf_search", 1'b0, 1'b0);
      body(V, -1);
      vsync_check("uf_cnt1", 1'b0, 1'b0);
      body(V, -1);
      vsync_check("uf_relock", 1'b0, 1'b1);

      // Short line: loses lock, and resets the match counter while measuring.
      body(V, V - 1);
      check("meas_h_799", {20'd0, mh_v}, H - 1);
      vsync_check("short_unlock", 1'b1, 1'b0);
      body(V, -1);
      vsync_check("s_measure", 1'b0, 1'b0);
      body(V, -1);
      vsync_check("s_cnt1", 1'b0, 1'b0);
      body(V, 1);
      vsync_check("s_cnt_clr", 1'b0, 1'b0);
      body(V, -1);
      vsync_check("s_cnt1b", 1'b0, 1'b0);
      body(V, -1);
      vsync_check("s_relock", 1'b0, 1'b1);

      // Reset mid-frame while locked.
      body(2, -1);
      hs = 1'b1; de = 1'b1; vid_data = 24'hABCDEF; tick();
      rst_n = 1'b0; tick(); tick();
      check("mid_rst_tx", {4'd0, tx_v}, 32'd0);
      check("mid_rst_locked", {31'd0, locked_v}, 32'd0);
      check("mid_rst_meas", {8'd0, mh_v, mv_v}, 32'd0);
      check("mid_rst_sticky", {31'd0, sticky_v}, 32'd0);
      hs = 1'b0; de = 1'b0; vid_data = 24'h0;
      rst_n = 1'b1; tick();
      line(H);
      vsync_check("r_discard", 1'b0, 1'b0);
      body(V, -1);
      vsync_check("r_cnt1", 1'b0, 1'b0);
      body(V, -1);
      vsync_check("r_relock", 1'b0, 1'b1);
      check("r_meas_h", {20'd0, mh_v}, H);
      check("r_meas_v", {20'd0, mv_v}, V);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lvds_lcd_mapper.md
LVDS_LCD_MAPPER -- requirements
Module: lvds_lcd_mapper

Interface
REQ-001 Parameter H_ACTIVE, default 800, expected active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, expected active lines per frame.
REQ-003 Parameter LOCK_FRAMES, default 2, range 1..15, consecutive matching frames required for lock.
REQ-004 Parameter JEIDA, default 0; 0 selects VESA bit mapping, 1 selects JEIDA.
REQ-005 Port clk_clk, input, 1, pixel clock and sole clock; all logic SHALL be on its rising edge.
REQ-006 Port reset_reset_n, input, 1, reset, synchronous and active-low.
REQ-007 Port vid_data, input, 24, pixel from the clocked video output: R=[23:16], G=[15:8], B=[7:0].
REQ-008 Port vid_datavalid, input, 1, active-video qualifier.
REQ-009 Port vid_h_sync, input, 1, horizontal sync, active-high.
REQ-010 Port vid_v_sync, input, 1, vertical sync, active-high.
REQ-011 Port vid_underflow, input, 1, upstream FIFO underflow pulse.
REQ-012 Port clear_err, input, 1, single-cycle pulse that clears underflow_sticky.
REQ-013 Port lvds_tx_data, output, 28, parallel word for 7:1 serializer: {lane3, lane2, lane1, lane0}, 7 bits each, bit 6 transmitted first.
REQ-014 Port frame_locked, output, 1, high while state is LOCKED.
REQ-015 Port underflow_sticky, output, 1, latched underflow flag.
REQ-016 Port meas_h, output, 12, active pixel count of the last complete line.
REQ-017 Port meas_v, output, 12, active line count of the last complete frame.

Function
REQ-018 Input signals SHALL be registered once (stage 1); lvds_tx_data SHALL be registered from stage 1 (stage 2), giving a fixed 2-cycle latency from input to lvds_tx_data.
REQ-019 VESA mapping: lane0={G0,R5..R0}; lane1={B1,B0,G5..G1}; lane2={DE,VS,HS,B5..B2}; lane3={0,B7,B6,G7,G6,R7,R6}.
REQ-020 JEIDA mapping: lane0={G2,R7..R2}; lane1={B3,B2,G7..G3}; lane2={DE,VS,HS,B7..B4}; lane3={0,B1,B0,G1,G0,R1,R0}.
REQ-021 HS and VS SHALL always pass through, delayed by 2 cycles, in every state.
REQ-022 When frame_locked is low, DE and all RGB bits in lvds_tx_data SHALL be 0.
REQ-023 Line measurement: a counter SHALL increment on each datavalid cycle; on the datavalid falling edge it SHALL load meas_h and clear. It SHALL saturate at 4095.
REQ-024 Frame measurement: datavalid rising edges SHALL be counted; on the vid_v_sync rising edge the count SHALL load meas_v and clear. It SHALL saturate at 4095.
REQ-025 A frame "matches" when, at its v_sync rising edge, every line in the frame had meas_h==H_ACTIVE and the line count equals V_ACTIVE.
REQ-026 The state machine SHALL have states SEARCH, MEASURE, and LOCKED.
REQ-027 SEARCH -> MEASURE on the first v_sync rising edge; the match counter SHALL clear.
REQ-028 In MEASURE, each matching frame SHALL increment the match counter; a non-matching frame SHALL clear it and keep the state MEASURE. The state SHALL move to LOCKED when the counter reaches LOCK_FRAMES.
REQ-029 LOCKED -> SEARCH on a non-matching frame or on vid_underflow=1.
REQ-030 vid_underflow=1 in any state SHALL force SEARCH on the next cycle and set underflow_sticky.
REQ-031 Blanking SHALL take effect on lvds_tx_data at the same pipeline point as the pixel that caused it.
REQ-032 clear_err SHALL clear underflow_sticky; if clear_err and vid_underflow occur in the same cycle, the set SHALL win.
REQ-033 The frame in progress when the block enters SEARCH SHALL NOT be counted as a match.

Reset
REQ-034 While reset_reset_n=0 at a clock edge:
- state SHALL go to SEARCH;
- counters SHALL clear;
- lvds_tx_data, frame_locked, underflow_sticky, meas_h, and meas_v SHALL be 0.
REQ-035 Reset asserted mid-frame SHALL discard the partial frame; measurement restarts from the next v_sync rising edge.

Verification
REQ-036 800x480 timing, LOCK_FRAMES=2 -> frame_locked rises 1 cycle after the 3rd v_sync rising edge; meas_h=800, meas_v=480.
REQ-037 Locked, vid_data=24'hFF0000, VESA -> 2 cycles later lane0=7'h3F, lane3=7'h03, DE=1; same stimulus with JEIDA=1 -> lane0=7'h3F, lane3=7'h03.
REQ-038 Locked, single-cycle vid_underflow -> frame_locked=0 next cycle, DE blanked, underflow_sticky=1; clear_err -> sticky=0; relocks after 2 good frames.
REQ-039 One line of 799 pixels within a frame -> no lock (or loss of lock), match counter reset; meas_h=799 after that line.
REQ-040 Reset pulsed mid-frame while locked -> all outputs 0; lock returns only after 1 full discarded frame plus 2 matching frames.
REQ-041 clear_err and vid_underflow in the same cycle -> underflow_sticky=1.
